ctrl_axil_master: RTL

Bridges the control-path word-access handshake onto an AXI4-Lite master port. It sits directly downstream of the host command controller: it accepts one address per access and, for writes, one data word, then performs one AXI4-Lite transaction and returns read data or a write acknowledgement. Each transaction that completes with a non-OKAY response sets a sticky error status for software.

---
 rtl/ctrl_axil_master_pkg.sv | 15 +
 rtl/ctrl_axil_master.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_axil_master_pkg.sv
// Shared definitions for the control-path AXI4-Lite master: data word and
// byte widths plus the AXI response codes used for error tracking.
// No logic; constants only.
package ctrl_axil_master_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int STRB_W = WORD_W / BYTE_W;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ctrl_axil_master.sv
// Purpose: bridges the upstream word-access handshake (address on i_common, then
//   write data on i_common) onto one AXI4-Lite transaction at a time; sticky error on non-OKAY.
// Latency: read addr->read_data_valid 3 cycles min; write addr->write ack 4 cycles min.
// Backpressure: slave stalls hold the FSM in place (no timeout); upstream stalls hold RD_HOLD.
// Ports: upstream i_addr_valid/o_addr_ready, i_write_data_valid/o_write_data_ready,
//   o_read_data_valid/i_read_data_ready, i_common; AXI4-Lite m_* (AW/W/B/AR/R);
//   error status i_err_clear/o_err/o_err_resp; o_busy.
module ctrl_axil_master
    import ctrl_axil_master_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_addr_valid,
    input  logic              i_write_enable,
    input  logic              i_write_data_valid,
    input  logic              i_read_data_ready,
    input  logic [WORD_W-1:0] i_common,
    output logic              o_addr_ready,
    output logic              o_write_data_ready,
    output logic              o_read_data_valid,
    output logic [WORD_W-1:0] o_read_data,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [WORD_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [WORD_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic              i_err_clear,
    output logic              o_err,
    output logic [1:0]        o_err_resp,
    output logic              o_busy
);

    typedef enum logic [7:0] {
        S_IDLE    = 8'b0000_0001,
        S_RD_AR   = 8'b0000_0010,
        S_RD_R    = 8'b0000_0100,
        S_RD_HOLD = 8'b0000_1000,
        S_WR_DATA = 8'b0001_0000,
        S_WR_AW_W = 8'b0010_0000,
        S_WR_B    = 8'b0100_0000,
        S_WR_ACK  = 8'b1000_0000
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_rdata;
    logic [WORD_W-1:0] r_wdata;
    logic              aw_done;
    logic              w_done;

    // Size cast zero-extends or truncates the upstream word; the low two bits are dropped
    // so every access is word aligned.
    logic [ADDR_W-1:0] addr_aligned;
    assign addr_aligned = ADDR_W'(i_common) & ~ADDR_W'(3);

    // A channel counts as finished once it has handshaken earlier or is handshaking now.
    logic aw_ok;
    logic w_ok;
    assign aw_ok = aw_done | m_awready;
    assign w_ok  = w_done  | m_wready;

    // Response evaluation happens on the R or B handshake only.
    logic       rsp_evt;
    logic [1:0] rsp_code;
    logic       err_set;
    assign rsp_evt  = ((state == S_RD_R) && m_rvalid) || ((state == S_WR_B) && m_bvalid);
    assign rsp_code = (state == S_RD_R) ? m_rresp : m_bresp;
    assign err_set  = rsp_evt && (rsp_code != AXI_RESP_OKAY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (i_addr_valid) state_nxt = i_write_enable ? S_WR_DATA : S_RD_AR;
            S_RD_AR:   if (m_arready) state_nxt = S_RD_R;
            S_RD_R:    if (m_rvalid) state_nxt = S_RD_HOLD;
            S_RD_HOLD: if (i_read_data_ready) state_nxt = S_IDLE;
            S_WR_DATA: if (i_write_data_valid) state_nxt = S_WR_AW_W;
            S_WR_AW_W: if (aw_ok && w_ok) state_nxt = S_WR_B;
            S_WR_B:    if (m_bvalid) state_nxt = S_WR_ACK;
            S_WR_ACK:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_rdata <= '0;
            r_wdata <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if ((state == S_IDLE) && i_addr_valid) begin
                r_addr <= addr_aligned;
            end
            if ((state == S_RD_R) && m_rvalid) begin
                r_rdata <= m_rdata;
            end
            if ((state == S_WR_DATA) && i_write_data_valid) begin
                r_wdata <= i_common;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == S_WR_AW_W) begin
                if (m_awready) aw_done <= 1'b1;
                if (m_wready)  w_done  <= 1'b1;
            end
        end
    end

    // Set has priority over clear so an error arriving with a clear is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_err      <= 1'b0;
            o_err_resp <= AXI_RESP_OKAY;
        end else if (err_set) begin
            o_err      <= 1'b1;
            o_err_resp <= rsp_code;
        end else if (i_err_clear) begin
            o_err      <= 1'b0;
        end
    end

    assign o_addr_ready       = (state == S_IDLE) && i_addr_valid;
    assign o_write_data_ready = (state == S_WR_ACK);
    assign o_read_data_valid  = (state == S_RD_HOLD);
    assign o_read_data        = r_rdata;
    assign m_awaddr           = r_addr;
    assign m_awvalid          = (state == S_WR_AW_W) && !aw_done;
    assign m_wdata            = r_wdata;
    assign m_wstrb            = '1;
    assign m_wvalid           = (state == S_WR_AW_W) && !w_done;
    assign m_bready           = (state == S_WR_B);
    assign m_araddr           = r_addr;
    assign m_arvalid          = (state == S_RD_AR);
    assign m_rready           = (state == S_RD_R);
    assign o_busy             = (state != S_IDLE);

endmodule
